mem_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of the execute stage.
- Owns the EX/MEM pipeline register and issues at most one data-memory access per instruction over a variable-latency req/ack port.
- Extracts and extends load data, and produces the MEM->WB bus and the MEM->ID forwarding bus.
- Raises a stall request while an access is outstanding.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_load_align.sv | 33 +++
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load opcodes and the EX/MEM register layout
// for the memory-access stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 111;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;
    localparam int STALL_BUS_WD = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [2:0] MEM_OP_LB  = 3'b000;
    localparam logic [2:0] MEM_OP_LBU = 3'b001;
    localparam logic [2:0] MEM_OP_LH  = 3'b010;
    localparam logic [2:0] MEM_OP_LHU = 3'b011;
    localparam logic [2:0] MEM_OP_LW  = 3'b100;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_WAIT,
        ACC_DONE
    } acc_state_e;

    // Field order mirrors ex_to_mem_bus, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  mem_op;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic [31:0] store_data;
    } ex_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the byte/half lane from the raw word
// and sign- or zero-extends it according to mem_op.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  mem_op_i,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
        half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];

        case (mem_op_i)
            MEM_OP_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LBU: load_data_o = {24'h0, byte_sel};
            MEM_OP_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LHU: load_data_o = {16'h0, half_sel};
            default:    load_data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, one data-memory access per instruction
// over a variable-latency req/ack port, load alignment, WB and forwarding buses.
module mem_stage #(
    parameter int EX_TO_MEM_WD = mem_stage_pkg::EX_TO_MEM_WD,
    parameter int MEM_TO_WB_WD = mem_stage_pkg::MEM_TO_WB_WD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id_forwarding,
    output logic                    stallreq_for_mem,
    output logic                    data_req,
    output logic [3:0]              data_wen,
    output logic [31:0]             data_addr,
    output logic [31:0]             data_wdata,
    input  logic                    data_ack,
    input  logic [31:0]             data_rdata
);

    import mem_stage_pkg::*;

    ex_mem_t     ex_mem_q;
    acc_state_e  state_q, state_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        bubble, load_new, advance;
    logic [31:0] raw, load_data, mem_result;
    logic        unused_stall;

    assign unused_stall = ^{stall[5], stall[2:0]};

    assign bubble   = (stall[3] == STOP) && (stall[4] == NO_STOP);
    assign load_new = (stall[3] == NO_STOP);
    assign advance  = bubble || load_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else if (bubble) begin
            ex_mem_q <= '0;
        end else if (load_new) begin
            ex_mem_q <= ex_to_mem_bus;
        end
    end

    // Any register advance restarts the handshake for the next instruction;
    // the controller keeps stall[3] asserted while stallreq_for_mem is high.
    always_comb begin
        state_d = state_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            ACC_IDLE: begin
                if (ex_mem_q.data_ram_en) begin
                    if (data_ack) begin
                        rbuf_d  = data_rdata;
                        state_d = ACC_DONE;
                    end else begin
                        state_d = ACC_WAIT;
                    end
                end
            end
            ACC_WAIT: begin
                if (data_ack) begin
                    rbuf_d  = data_rdata;
                    state_d = ACC_DONE;
                end
            end
            default: ;
        endcase
        if (advance) begin
            state_d = ACC_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC_IDLE;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign data_req = ((state_q == ACC_IDLE) && ex_mem_q.data_ram_en)
                   || (state_q == ACC_WAIT);

    assign data_wen         = data_req ? ex_mem_q.data_ram_wen : '0;
    assign data_addr        = data_req ? ex_mem_q.ex_result    : '0;
    assign data_wdata       = data_req ? ex_mem_q.store_data   : '0;
    assign stallreq_for_mem = data_req & ~data_ack;

    assign raw = data_ack ? data_rdata : rbuf_q;

    mem_load_align u_load_align (
        .raw_i       (raw),
        .addr_i      (ex_mem_q.ex_result[1:0]),
        .mem_op_i    (ex_mem_q.mem_op),
        .load_data_o (load_data)
    );

    assign mem_result = (ex_mem_q.sel_rf_res && ex_mem_q.data_ram_en
                         && (ex_mem_q.data_ram_wen == 4'h0))
                      ? load_data : ex_mem_q.ex_result;

    assign mem_to_wb_bus        = {ex_mem_q.pc, ex_mem_q.rf_we, ex_mem_q.rf_waddr, mem_result};
    assign mem_to_id_forwarding = {ex_mem_q.rf_we, ex_mem_q.rf_waddr, mem_result};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a latency-programmable memory responder,
// expected WB words queued at issue and popped when the access completes.
module tb_mem_stage;

    localparam logic [5:0] STALL_NONE   = 6'b000000;
    localparam logic [5:0] STALL_HOLD   = 6'b011111;
    localparam logic [5:0] STALL_BUBBLE = 6'b001111;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [110:0] ex_to_mem_bus;
    logic [69:0]  mem_to_wb_bus;
    logic [37:0]  mem_to_id_forwarding;
    logic         stallreq_for_mem;
    logic         data_req;
    logic [3:0]   data_wen;
    logic [31:0]  data_addr;
    logic [31:0]  data_wdata;
    logic         data_ack;
    logic [31:0]  data_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [69:0] sb_q[$];

    always #5 clk = ~clk;

    mem_stage #(.EX_TO_MEM_WD(111), .MEM_TO_WB_WD(70)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .ex_to_mem_bus        (ex_to_mem_bus),
        .mem_to_wb_bus        (mem_to_wb_bus),
        .mem_to_id_forwarding (mem_to_id_forwarding),
        .stallreq_for_mem     (stallreq_for_mem),
        .data_req             (data_req),
        .data_wen             (data_wen),
        .data_addr            (data_addr),
        .data_wdata           (data_wdata),
        .data_ack             (data_ack),
        .data_rdata           (data_rdata)
    );

    task automatic check(input string tag, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [110:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                        input logic en, input logic [3:0] wen,
                                        input logic sel, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] exr,
                                        input logic [31:0] sd);
        return {pc, op, en, wen, sel, we, waddr, exr, sd};
    endfunction

    // Entered and left at posedge+1. Memory acks after `lat` request cycles;
    // `hold` extra stalled cycles follow completion with the register frozen.
    task automatic run_instr(input logic [110:0] bus, input int lat, input logic [31:0] rdata,
                             input int hold, input logic [31:0] exp_res,
                             output int req_n, output int stall_n);
        logic [69:0] exp_wb;
        int req_cnt;
        bit done;
        exp_wb = '0;
        sb_q.push_back({bus[110:79], bus[69], bus[68:64], exp_res});
        ex_to_mem_bus = bus;
        stall         = STALL_NONE;
        data_ack      = 1'b0;
        data_rdata    = rdata;
        @(posedge clk); #1;
        ex_to_mem_bus = '0;
        req_n = 0; stall_n = 0; req_cnt = 0; done = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            data_ack = data_req && (req_cnt == lat);
            #1;
            if (data_req) begin
                req_n++;
                req_cnt++;
                check("req_addr", data_addr, bus[63:32]);
                check("req_wen", data_wen, bus[74:71]);
                check("req_wdata", data_wdata, bus[31:0]);
            end else begin
                check("idle_addr", data_addr, 32'h0);
            end
            if (stallreq_for_mem) begin
                stall_n++;
                stall = STALL_HOLD;
            end else begin
                done   = 1'b1;
                exp_wb = sb_q.pop_front();
                check("wb_bus", mem_to_wb_bus, exp_wb);
                check("fwd_bus", mem_to_id_forwarding, exp_wb[37:0]);
                stall = (hold > 0) ? STALL_HOLD : STALL_NONE;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            check("timeout", {69'h0, done}, 70'h1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            stall = STALL_NONE;
        end
        data_ack = 1'b0;
        for (int h = 0; h < hold; h++) begin
            #1;
            if (data_req) req_n++;
            check("hold_wb", mem_to_wb_bus, exp_wb);
            if (h == hold - 1) stall = STALL_NONE;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          lat;
        int          hold;
        logic [31:0] exp;
    } ld_t;

    ld_t loads[8];

    initial begin
        int req_n, stall_n;
        logic [110:0] bus_a, bus_b;

        loads[0] = '{3'b100, 32'h100, 32'h8899AABB, 0, 0, 32'h8899AABB};
        loads[1] = '{3'b000, 32'h103, 32'h80FF7F01, 3, 2, 32'hFFFFFF80};
        loads[2] = '{3'b011, 32'h102, 32'hBEEF1234, 1, 0, 32'h0000BEEF};
        loads[3] = '{3'b010, 32'h100, 32'hBEEF1234, 0, 0, 32'h00001234};
        loads[4] = '{3'b010, 32'h102, 32'hBEEF1234, 2, 0, 32'hFFFFBEEF};
        loads[5] = '{3'b001, 32'h101, 32'h80FF7F01, 0, 1, 32'h0000007F};
        loads[6] = '{3'b010, 32'h101, 32'hBEEF1234, 0, 0, 32'h00001234};
        loads[7] = '{3'b111, 32'h100, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D};

        rst           = 1'b1;
        stall         = STALL_NONE;
        ex_to_mem_bus = mk(32'h1234, 3'b100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h40, 32'h0);
        data_ack      = 1'b1;
        data_rdata    = 32'h5555AAAA;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb", mem_to_wb_bus, 70'h0);
        check("rst_fwd", mem_to_id_forwarding, 38'h0);
        check("rst_req", data_req, 1'b0);
        check("rst_stallreq", stallreq_for_mem, 1'b0);
        check("rst_addr", data_addr, 32'h0);
        rst           = 1'b0;
        ex_to_mem_bus = '0;
        data_ack      = 1'b0;
        @(posedge clk); #1;

        foreach (loads[i]) begin
            run_instr(mk(32'hBFC0_0000 + 32'(i * 4), loads[i].op, 1'b1, 4'h0, 1'b1, 1'b1,
                         5'(i + 1), loads[i].addr, 32'h0),
                      loads[i].lat, loads[i].rdata, loads[i].hold, loads[i].exp,
                      req_n, stall_n);
            check($sformatf("ld%0d_req_cycles", i), 70'(req_n), 70'(loads[i].lat + 1));
            check($sformatf("ld%0d_stall_cycles", i), 70'(stall_n), 70'(loads[i].lat));
        end

        // Store: one request only, even across a 4-cycle freeze in DONE.
        run_instr(mk(32'hBFC0_0100, 3'b100, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h200, 32'hDEADBEEF),
                  2, 32'h0, 4, 32'h200, req_n, stall_n);
        check("sw_req_cycles", 70'(req_n), 70'd3);
        check("sw_stall_cycles", 70'(stall_n), 70'd2);

        // Hold then bubble: a non-memory op sits in the register, then is squashed.
        bus_a = mk(32'hBFC0_0200, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h12345678, 32'h0);
        bus_b = mk(32'hBFC0_0204, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h0BADF00D, 32'h0);
        ex_to_mem_bus = bus_a;
        stall         = STALL_NONE;
        @(posedge clk); #1;
        ex_to_mem_bus = bus_b;
        stall         = STALL_HOLD;
        #1;
        check("alu_wb", mem_to_wb_bus, {32'hBFC0_0200, 1'b1, 5'd7, 32'h12345678});
        check("alu_req", data_req, 1'b0);
        @(posedge clk); #1;
        check("hold_keeps", mem_to_wb_bus, {32'hBFC0_0200, 1'b1, 5'd7, 32'h12345678});
        stall = STALL_BUBBLE;
        @(posedge clk); #1;
        check("bubble_wb", mem_to_wb_bus, 70'h0);
        check("bubble_fwd_we", mem_to_id_forwarding[37], 1'b0);
        stall         = STALL_NONE;
        ex_to_mem_bus = '0;
        @(posedge clk); #1;

        // Reset while WAIT is outstanding.
        ex_to_mem_bus = mk(32'hBFC0_0300, 3'b100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h300, 32'h0);
        data_ack      = 1'b0;
        @(posedge clk); #1;
        ex_to_mem_bus = '0;
        #1;
        check("pre_rst_stallreq", stallreq_for_mem, 1'b1);
        stall = STALL_HOLD;
        @(posedge clk); #1;
        check("wait_req", data_req, 1'b1);
        check("wait_addr", data_addr, 32'h300);
        rst = 1'b1;
        @(posedge clk); #1;
        check("wrst_req", data_req, 1'b0);
        check("wrst_stallreq", stallreq_for_mem, 1'b0);
        check("wrst_wb", mem_to_wb_bus, 70'h0);
        check("wrst_fwd", mem_to_id_forwarding, 38'h0);
        rst   = 1'b0;
        stall = STALL_NONE;
        @(posedge clk); #1;
        check("post_rst_req", data_req, 1'b0);

        run_instr(mk(32'hBFC0_0400, 3'b100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h104, 32'h0),
                  1, 32'h01020304, 0, 32'h01020304, req_n, stall_n);
        check("after_rst_req_cycles", 70'(req_n), 70'd2);
        check("sb_empty", 70'(sb_q.size()), 70'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
